// File: rtl/fpu_pkg.sv
// Shared FP32 types, constants and the round-to-nearest-even helper for the adder datapath.
package fpu_pkg;

  localparam int FP_EXP_W  = 8;
  localparam int FP_FRAC_W = 23;
  localparam int FP_MANT_W = FP_FRAC_W + 1;
  localparam int FP_LZ_W   = 5;
  localparam int EXP_BIAS  = 127;
  localparam int EXP_MAX   = 255;

  typedef struct packed {
    logic                 sign;
    logic [FP_EXP_W-1:0]  exp;
    logic [FP_FRAC_W-1:0] mant;
  } fp32_t;

  // Stage-1 register contents: raw sum plus the leading-zero count.
  typedef struct packed {
    logic                 sign;
    logic [FP_EXP_W-1:0]  exp;
    logic [FP_MANT_W-1:0] mant;
    logic [2:0]           grs;
    logic [FP_LZ_W-1:0]   lz;
    logic                 carry;
    logic                 zero;
  } norm_in_t;

  // Returns {carry_out, mantissa}; a set carry_out means the mantissa wrapped past 1.111...
  function automatic logic [FP_MANT_W:0] round_rne(
    input logic [FP_MANT_W-1:0] mant,
    input logic                 g,
    input logic                 r,
    input logic                 s
  );
    logic inc;
    inc = g & (r | s | mant[0]);
    return {1'b0, mant} + {{FP_MANT_W{1'b0}}, inc};
  endfunction

endpackage

// File: rtl/fpu_add_normalize_lopd.sv
// Leading-one detector: counts zeros above the first set bit of a 24-bit mantissa.
// Combinational, no latency; no handshake (pure function of its input).
// An all-zero input raises zero and reports lz = 0.
module fpu_add_normalize_lopd (
  input  logic [23:0] mant,
  output logic [4:0]  lz,
  output logic        zero
);

  // Scan upward so the highest set bit has the final say.
  always_comb begin
    lz = 5'd0;
    for (int i = 0; i < 24; i++) begin
      if (mant[i]) lz = 5'(23 - i);
    end
  end

  assign zero = ~|mant;

endmodule

// File: rtl/fpu_add_normalize.sv
// FP32 adder post-normalise and RNE round stage, packing an IEEE-754 single result.
// Latency: 2 cycles (stage 1 = LOPD register, stage 2 = normalise/round/pack register).
// Backpressure: each stage holds while its successor is full and not draining; o_ready = !s1_valid | s2_advance.
module fpu_add_normalize
  import fpu_pkg::*;
#(
  parameter int SIZE_MANT = 24,
  parameter int SIZE_EXP  = 8,
  parameter int SIZE_LOPD = 5
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_valid,
  output logic                o_ready,
  input  logic                i_sign,
  input  logic [SIZE_EXP-1:0] i_exp,
  input  logic [SIZE_MANT:0]  i_mant,
  input  logic [2:0]          i_grs,
  output logic                o_valid,
  input  logic                i_ready,
  output logic [31:0]         o_result,
  output logic                o_overflow,
  output logic                o_underflow
);

  logic [SIZE_LOPD-1:0] lz;
  logic                 mant_zero;
  norm_in_t             s1_d;
  norm_in_t             s1;
  logic                 s1_valid;
  logic                 s2_advance;

  fpu_add_normalize_lopd u_lopd (
    .mant (i_mant[SIZE_MANT-1:0]),
    .lz   (lz),
    .zero (mant_zero)
  );

  always_comb begin
    s1_d.sign  = i_sign;
    s1_d.exp   = i_exp;
    s1_d.mant  = i_mant[SIZE_MANT-1:0];
    s1_d.grs   = i_grs;
    s1_d.lz    = lz;
    s1_d.carry = i_mant[SIZE_MANT];
    s1_d.zero  = mant_zero;
  end

  assign s2_advance = !o_valid || i_ready;
  assign o_ready    = !s1_valid || s2_advance;

  // Stage 2: normalise into a 27-bit {mant, G, R, S} window.
  logic signed [9:0] exp10;
  logic        [5:0] lz_eff;
  logic        [7:0] sub_sh;
  logic       [26:0] sh;
  logic       [23:0] n_mant;
  logic              n_g;
  logic              n_r;
  logic              n_s;
  logic signed [9:0] n_exp;
  logic              subn;
  logic       [24:0] rnd;
  logic signed [9:0] f_exp;
  logic       [22:0] f_frac;
  fp32_t             res;
  logic              ovf;
  logic              unf;

  always_comb begin
    exp10  = $signed({2'b00, s1.exp});
    // A zero mantissa with live guard/round bits normalises from below bit 0.
    lz_eff = s1.zero ? 6'd24 : {1'b0, s1.lz};
    sub_sh = (s1.exp == 8'd0) ? 8'd0 : s1.exp - 8'd1;
    sh     = '0;
    n_mant = s1.mant;
    n_g    = s1.grs[2];
    n_r    = s1.grs[1];
    n_s    = s1.grs[0];
    n_exp  = exp10;
    subn   = 1'b0;
    if (s1.carry) begin
      n_mant = {1'b1, s1.mant[23:1]};
      n_g    = s1.mant[0];
      n_r    = s1.grs[2];
      n_s    = s1.grs[1] | s1.grs[0];
      n_exp  = exp10 + 10'sd1;
    end else if ({4'b0000, lz_eff} < {2'b00, s1.exp}) begin
      // Sticky stays put; the bottom slot only ever receives shifted-in zeros.
      sh     = {s1.mant, s1.grs[2:1], 1'b0} << lz_eff;
      n_mant = sh[26:3];
      n_g    = sh[2];
      n_r    = sh[1];
      n_s    = s1.grs[0] | sh[0];
      n_exp  = exp10 - $signed({4'b0000, lz_eff});
    end else begin
      // Stop at the minimum exponent: exponent field 0 encodes the same scale as 1.
      sh     = {s1.mant, s1.grs[2:1], 1'b0} << sub_sh;
      n_mant = sh[26:3];
      n_g    = sh[2];
      n_r    = sh[1];
      n_s    = s1.grs[0] | sh[0];
      n_exp  = 10'sd0;
      subn   = 1'b1;
    end
  end

  always_comb begin
    rnd = round_rne(n_mant, n_g, n_r, n_s);
    if (rnd[24]) begin
      f_frac = 23'd0;
      f_exp  = n_exp + 10'sd1;
    end else begin
      f_frac = rnd[22:0];
      // A subnormal that rounds up into the hidden bit becomes the smallest normal.
      f_exp  = subn ? (rnd[23] ? 10'sd1 : 10'sd0) : n_exp;
    end
  end

  always_comb begin
    res  = '0;
    ovf  = 1'b0;
    unf  = 1'b0;
    if (s1.zero && !s1.carry && (s1.grs == 3'b000)) begin
      res.sign = s1.sign;
    end else if (f_exp >= $signed(10'(EXP_MAX))) begin
      res.sign = s1.sign;
      res.exp  = 8'hFF;
      ovf      = 1'b1;
    end else begin
      res.sign = s1.sign;
      res.exp  = f_exp[7:0];
      res.mant = f_frac;
      unf      = subn;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s1_valid    <= 1'b0;
      s1          <= '0;
      o_valid     <= 1'b0;
      o_result    <= '0;
      o_overflow  <= 1'b0;
      o_underflow <= 1'b0;
    end else begin
      if (o_ready) begin
        s1_valid <= i_valid;
        if (i_valid) s1 <= s1_d;
      end
      if (s2_advance) begin
        o_valid <= s1_valid;
        if (s1_valid) begin
          o_result    <= res;
          o_overflow  <= ovf;
          o_underflow <= unf;
        end
      end
    end
  end

endmodule

// File: tb/tb_fpu_add_normalize.sv
// Scoreboard bench for fpu_add_normalize: hand-computed FP32 vectors, streaming, stall and reset scenarios.
module tb_fpu_add_normalize;
  import fpu_pkg::*;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [24:0] mant;
    logic [2:0]  grs;
    logic [31:0] res;
    logic        ovf;
    logic        unf;
  } vec_t;

  typedef struct packed {
    logic [31:0] res;
    logic        ovf;
    logic        unf;
  } exp_t;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_valid;
  logic        o_ready;
  logic        i_sign;
  logic [7:0]  i_exp;
  logic [24:0] i_mant;
  logic [2:0]  i_grs;
  logic        o_valid;
  logic        i_ready;
  logic [31:0] o_result;
  logic        o_overflow;
  logic        o_underflow;

  vec_t vecs[$];
  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 i_clk = ~i_clk;

  fpu_add_normalize dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_valid     (i_valid),
    .o_ready     (o_ready),
    .i_sign      (i_sign),
    .i_exp       (i_exp),
    .i_mant      (i_mant),
    .i_grs       (i_grs),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_result    (o_result),
    .o_overflow  (o_overflow),
    .o_underflow (o_underflow)
  );

  task automatic add_vec(input logic s, input logic [7:0] e, input logic [24:0] m, input logic [2:0] g,
                         input logic [31:0] r, input logic ov, input logic un);
    vec_t v;
    v.sign = s; v.exp = e; v.mant = m; v.grs = g; v.res = r; v.ovf = ov; v.unf = un;
    vecs.push_back(v);
  endtask

  task automatic apply(input vec_t v);
    i_sign = v.sign;
    i_exp  = v.exp;
    i_mant = v.mant;
    i_grs  = v.grs;
  endtask

  function automatic exp_t expect_of(input vec_t v);
    exp_t e;
    e.res = v.res; e.ovf = v.ovf; e.unf = v.unf;
    return e;
  endfunction

  task automatic build_vectors();
    add_vec(1'b0, 8'(EXP_BIAS),  25'h1000000, 3'b000, 32'h40000000, 1'b0, 1'b0); // 0 carry
    add_vec(1'b0, 8'(EXP_BIAS),  25'h0000001, 3'b000, 32'h34000000, 1'b0, 1'b0); // 1 lz = 23
    add_vec(1'b0, 8'd3,          25'h0000100, 3'b000, 32'h00000400, 1'b0, 1'b1); // 2 subnormal
    add_vec(1'b0, 8'(EXP_MAX-1), 25'h1FFFFFF, 3'b111, 32'h7F800000, 1'b1, 1'b0); // 3 overflow
    add_vec(1'b0, 8'(EXP_BIAS),  25'h0800001, 3'b100, 32'h3F800002, 1'b0, 1'b0); // 4 tie, odd
    add_vec(1'b0, 8'(EXP_BIAS),  25'h0800002, 3'b100, 32'h3F800002, 1'b0, 1'b0); // 5 tie, even
    add_vec(1'b0, 8'(EXP_BIAS),  25'h0800000, 3'b101, 32'h3F800001, 1'b0, 1'b0); // 6 G+S
    add_vec(1'b0, 8'(EXP_BIAS),  25'h0FFFFFF, 3'b100, 32'h40000000, 1'b0, 1'b0); // 7 round carry-out
    add_vec(1'b0, 8'(EXP_BIAS),  25'h1000003, 3'b000, 32'h40000002, 1'b0, 1'b0); // 8 carry bit0->G
    add_vec(1'b1, 8'd100,        25'h0000000, 3'b000, 32'h80000000, 1'b0, 1'b0); // 9 exact zero
    add_vec(1'b0, 8'd1,          25'h07FFFFF, 3'b100, 32'h00800000, 1'b0, 1'b1); // 10 subnormal -> min normal
    add_vec(1'b0, 8'(EXP_BIAS),  25'h0400000, 3'b110, 32'h3F000002, 1'b0, 1'b0); // 11 G,R shifted in
    add_vec(1'b1, 8'(EXP_MAX-1), 25'h1000000, 3'b000, 32'hFF800000, 1'b1, 1'b0); // 12 neg overflow
    add_vec(1'b0, 8'd20,         25'h0000001, 3'b000, 32'h00080000, 1'b0, 1'b1); // 13 deep subnormal
    add_vec(1'b1, 8'(EXP_BIAS),  25'h0800000, 3'b000, 32'hBF800000, 1'b0, 1'b0); // 14 -1.0
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    i_ready = 1'b1;
    apply(vecs[0]);
    i_valid = 1'b1;
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    checks++;
    if (o_valid !== 1'b0) begin errors++; $display("FAIL reset o_valid: got %b expected 0", o_valid); end
    checks++;
    if (o_ready !== 1'b1) begin errors++; $display("FAIL reset o_ready: got %b expected 1", o_ready); end
    checks++;
    if (o_result !== 32'h0) begin errors++; $display("FAIL reset o_result: got %08h expected 00000000", o_result); end
    checks++;
    if (o_overflow !== 1'b0 || o_underflow !== 1'b0) begin
      errors++; $display("FAIL reset flags: got ovf=%b unf=%b expected 0/0", o_overflow, o_underflow);
    end
    i_rst = 1'b0;
    i_valid = 1'b0;
  endtask

  task automatic test_directed();
    exp_t e;
    int   lat;
    for (int k = 0; k < vecs.size(); k++) begin
      @(negedge i_clk);
      apply(vecs[k]);
      i_valid = 1'b1;
      i_ready = 1'b1;
      sb_q.push_back(expect_of(vecs[k]));
      @(negedge i_clk);
      i_valid = 1'b0;
      lat = 1;
      while (!o_valid && lat < 8) begin
        @(negedge i_clk);
        lat++;
      end
      e = sb_q.pop_front();
      checks++;
      if (lat != 2) begin errors++; $display("FAIL directed[%0d] latency: got %0d cycles expected 2", k, lat); end
      checks++;
      if (o_result !== e.res) begin errors++; $display("FAIL directed[%0d] result: got %08h expected %08h", k, o_result, e.res); end
      checks++;
      if (o_overflow !== e.ovf) begin errors++; $display("FAIL directed[%0d] overflow: got %b expected %b", k, o_overflow, e.ovf); end
      checks++;
      if (o_underflow !== e.unf) begin errors++; $display("FAIL directed[%0d] underflow: got %b expected %b", k, o_underflow, e.unf); end
    end
  endtask

  task automatic test_back_to_back();
    int   sent = 0;
    int   got = 0;
    int   first = -1;
    int   last = -1;
    int   ready_drops = 0;
    exp_t e;
    i_ready = 1'b1;
    for (int cyc = 0; cyc < 40 && got < 8; cyc++) begin
      @(negedge i_clk);
      if (sent < 8) begin apply(vecs[sent]); i_valid = 1'b1; end
      else i_valid = 1'b0;
      #1;
      if (i_valid && !o_ready) ready_drops++;
      if (o_valid) begin
        if (first < 0) first = cyc;
        last = cyc;
        got++;
        checks++;
        if (sb_q.size() == 0) begin
          errors++; $display("FAIL b2b unexpected output: got %08h expected none", o_result);
        end else begin
          e = sb_q.pop_front();
          if (o_result !== e.res || o_overflow !== e.ovf || o_underflow !== e.unf) begin
            errors++;
            $display("FAIL b2b item %0d: got %08h/%b/%b expected %08h/%b/%b", got - 1,
                     o_result, o_overflow, o_underflow, e.res, e.ovf, e.unf);
          end
        end
      end
      if (i_valid && o_ready) begin
        sb_q.push_back(expect_of(vecs[sent]));
        sent++;
      end
    end
    i_valid = 1'b0;
    checks++;
    if (ready_drops != 0) begin errors++; $display("FAIL b2b o_ready drops: got %0d expected 0", ready_drops); end
    checks++;
    if (got != 8) begin errors++; $display("FAIL b2b count: got %0d expected 8", got); end
    checks++;
    if (first != 2) begin errors++; $display("FAIL b2b first output cycle: got %0d expected 2", first); end
    checks++;
    if (last - first != 7) begin errors++; $display("FAIL b2b output span: got %0d expected 7", last - first); end
  endtask

  task automatic test_backpressure();
    int          idx[4] = '{4, 6, 11, 1};
    int          sent = 0;
    int          got = 0;
    int          acc_at_drop = -1;
    logic [31:0] held = '0;
    logic        holding = 1'b0;
    exp_t        e;
    for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
      @(negedge i_clk);
      i_ready = (cyc >= 5);
      if (sent < 4) begin apply(vecs[idx[sent]]); i_valid = 1'b1; end
      else i_valid = 1'b0;
      #1;
      if (i_valid && !o_ready && acc_at_drop < 0) acc_at_drop = sent;
      if (o_valid && !i_ready) begin
        if (holding) begin
          checks++;
          if (o_result !== held) begin errors++; $display("FAIL stall hold: got %08h expected %08h", o_result, held); end
        end
        held = o_result;
        holding = 1'b1;
      end
      if (o_valid && i_ready) begin
        got++;
        checks++;
        if (sb_q.size() == 0) begin
          errors++; $display("FAIL stall unexpected output: got %08h expected none", o_result);
        end else begin
          e = sb_q.pop_front();
          if (o_result !== e.res || o_overflow !== e.ovf || o_underflow !== e.unf) begin
            errors++;
            $display("FAIL stall item %0d: got %08h/%b/%b expected %08h/%b/%b", got - 1,
                     o_result, o_overflow, o_underflow, e.res, e.ovf, e.unf);
          end
        end
      end
      if (i_valid && o_ready) begin
        sb_q.push_back(expect_of(vecs[idx[sent]]));
        sent++;
      end
    end
    i_valid = 1'b0;
    checks++;
    if (acc_at_drop != 2) begin errors++; $display("FAIL stall accepts before o_ready drop: got %0d expected 2", acc_at_drop); end
    checks++;
    if (got != 4) begin errors++; $display("FAIL stall result count: got %0d expected 4", got); end
    @(negedge i_clk);
    checks++;
    if (o_valid !== 1'b0) begin errors++; $display("FAIL stall duplicate: got o_valid %b expected 0", o_valid); end
  endtask

  task automatic test_reset_mid_stream();
    int spurious = 0;
    int lat = 0;
    i_ready = 1'b0;
    @(negedge i_clk);
    apply(vecs[3]);
    i_valid = 1'b1;
    @(negedge i_clk);
    apply(vecs[0]);
    @(negedge i_clk);
    apply(vecs[8]);
    #1;
    checks++;
    if (o_valid !== 1'b1 || o_overflow !== 1'b1) begin
      errors++; $display("FAIL pre-reset fill: got valid=%b ovf=%b expected 1/1", o_valid, o_overflow);
    end
    i_rst = 1'b1;
    @(negedge i_clk);
    checks++;
    if (o_valid !== 1'b0) begin errors++; $display("FAIL midreset o_valid: got %b expected 0", o_valid); end
    checks++;
    if (o_ready !== 1'b1) begin errors++; $display("FAIL midreset o_ready: got %b expected 1", o_ready); end
    checks++;
    if (o_result !== 32'h0 || o_overflow !== 1'b0 || o_underflow !== 1'b0) begin
      errors++;
      $display("FAIL midreset outputs: got %08h/%b/%b expected 00000000/0/0", o_result, o_overflow, o_underflow);
    end
    i_rst = 1'b0;
    i_valid = 1'b0;
    i_ready = 1'b1;
    repeat (4) begin
      @(negedge i_clk);
      if (o_valid) spurious++;
    end
    checks++;
    if (spurious != 0) begin errors++; $display("FAIL midreset flushed data emerged: got %0d outputs expected 0", spurious); end
    apply(vecs[14]);
    i_valid = 1'b1;
    @(negedge i_clk);
    i_valid = 1'b0;
    lat = 1;
    while (!o_valid && lat < 8) begin
      @(negedge i_clk);
      lat++;
    end
    checks++;
    if (o_valid !== 1'b1 || o_result !== vecs[14].res) begin
      errors++;
      $display("FAIL post-reset item: got valid=%b %08h expected 1 %08h", o_valid, o_result, vecs[14].res);
    end
  endtask

  initial begin
    i_rst   = 1'b1;
    i_valid = 1'b0;
    i_ready = 1'b1;
    i_sign  = 1'b0;
    i_exp   = '0;
    i_mant  = '0;
    i_grs   = '0;
    build_vectors();
    test_reset();
    test_directed();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_stream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/fpu_add_normalize.md
Name: fpu_add_normalize

Overview:
- Post-addition normalisation and rounding stage of the FP32 adder datapath.
- Takes the raw 25-bit mantissa sum (carry bit included), exponent, sign and guard/round/sticky (GRS) bits from the add/subtract stage.
- Normalises the mantissa with a leading-one detector, rounds round-to-nearest-even (RNE), and packs an IEEE-754 single-precision result.
- Two-stage valid/ready pipeline.

Parameters:
- SIZE_MANT, 24, mantissa width including hidden bit.
- SIZE_EXP, 8, exponent width.
- SIZE_LOPD, 5, leading-zero-count width.

Ports:
- i_clk  input  1  clock.
- i_rst  input  1  synchronous, active-high reset.
- i_valid  input  1  upstream data valid.
- o_ready  output  1  this block can accept data.
- i_sign  input  1  result sign.
- i_exp  input  8  biased exponent of the larger operand.
- i_mant  input  25  bit24 = carry out, bits[23:0] = sum mantissa.
- i_grs  input  3  guard, round, sticky from alignment.
- o_valid  output  1  result valid.
- i_ready  input  1  downstream accepts result.
- o_result  output  32  packed FP32 result.
- o_overflow  output  1  result rounded to infinity.
- o_underflow  output  1  result is subnormal or zero from a nonzero input.

Behaviour:
- Single clock i_clk. Reset is synchronous and active-high on i_rst.
- Reset values: both stage valid flags = 0, o_valid = 0, o_result = 0, o_overflow = 0, o_underflow = 0.
- o_ready = 1 after reset.
- Reset mid-operation discards all in-flight data. No output is produced for it.
- Handshake:
  - Transfer occurs when valid & ready are both 1.
  - Stage n advances when its output register is empty or being consumed in the same cycle.
  - o_ready = !s1_valid | s2_advance.
  - A full pipeline with i_ready = 1 accepts one item per cycle.
  - o_result, o_overflow and o_underflow are held stable while o_valid = 1 and i_ready = 0.
- Latency: 2 cycles from accept to o_valid when there is no backpressure.
- Stage 1:
  - LOPD on i_mant[23:0] gives lz, the leading-zero count (0..23). An all-zero mantissa flags zero.
  - Register sign, exp, mant, grs, lz, carry and zero.
- Stage 2, normalise:
  - carry = 1:
    - Shift right by 1; old bit0 becomes guard.
    - Round and sticky OR-fold into sticky.
    - exp + 1.
  - carry = 0 and lz < exp:
    - Shift left by lz, shifting in G then R then zeros.
    - Sticky is unchanged.
    - exp − lz.
  - carry = 0 and lz ≥ exp (subnormal):
    - Shift left by max(exp − 1, 0).
    - Exponent field = 0.
    - o_underflow = 1.
  - zero mantissa and grs = 0: result = {i_sign, 31'b0}, o_underflow = 0.
- Stage 2, round (RNE):
  - Increment when G & (R | S | LSB).
  - A mantissa carry-out from rounding gives exp + 1 and mantissa = 1.0.
  - A subnormal that rounds up to 0x800000 becomes exponent field 1.
- Overflow: a final exponent ≥ 255 gives {sign, 8'hFF, 23'b0} and o_overflow = 1.
- i_exp = 255 on input is outside this block's contract. Special values are handled upstream.
- Width rules:
  - Exponent arithmetic is done in 10-bit signed form so that underflow and overflow are detected without wrap-around.
  - The internal shifter is 27 bits wide: mantissa plus GRS.

Decomposition:
- Shared package fpu_pkg:
  - FP32 field widths.
  - EXP_BIAS = 127, EXP_MAX = 255.
  - Struct fp32_t {sign, exp, mant}.
  - Struct norm_in_t for the stage-1 register.
- Sub-module: the existing 24-bit LOPD, instantiated as a combinational leading-zero counter in stage 1.
- The rounding logic is an internal function in fpu_pkg, round_rne.

Test Plan:
- Carry: i_mant = 25'h1000000, i_exp = 127, grs = 0 → o_result = 32'h40000000 two cycles later.
- Massive cancellation: i_mant = 25'h0000001, i_exp = 127, grs = 0 → lz = 23, o_result = 32'h34000000.
- Subnormal: i_mant = 25'h0000100, i_exp = 3 → shift by 2 only, o_result = 32'h00000400, o_underflow = 1.
- Overflow: i_mant = 25'h1FFFFFF, i_exp = 254, grs = 3'b111 → o_result = 32'h7F800000, o_overflow = 1.
- RNE tie with odd LSB: i_mant = 25'h0800001, grs = 3'b100, i_exp = 127 → 32'h3F800002. With i_mant = 25'h0800002 → 32'h3F800002 (no increment).
- Backpressure:
  - Stream 4 items with i_ready = 0 for 3 cycles → o_ready drops after 2 accepts.
  - o_result is held stable during the stall.
  - All 4 results emerge in order, none dropped or duplicated.
  - Asserting i_rst mid-stream clears o_valid on the next edge.
